code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
- Parametrised keypad code-entry controller for the code_lock design.
- Collects CODE_LEN digits from the key debouncer/decoder and compares them against a stored code.
- Supports verified code change, a clear key, entry timeout, and lockout after repeated failures.
- Sits between the keypad scanner (key_sured/key_value) and the LED/display drivers.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 6, digits per code (2..15).
- DEFAULT_CODE, 24'h012345, reset code; width DIGIT_W*CODE_LEN; first digit in the MSBs.
- SAMPLE_DLY, 3, cycles from key_sured rising edge to key_value capture (1..7).
- MAX_FAIL, 3, consecutive failed comparisons that trigger lockout (1..15).
- LOCK_CYCLES, 50_000_000, lockout duration in clk cycles.
- TIMEOUT_CYCLES, 100_000_000, idle cycles that abort a partial entry.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- key_sured  in  1  key-valid level; its rising edge marks a new digit
- key_value  in  DIGIT_W  digit; stable SAMPLE_DLY cycles after the key_sured edge
- key_clear  in  1  level; rising edge clears the partial entry
- code_set_req  in  1  level; rising edge requests a code change
- code_finish_n  out  1  0 for exactly 1 cycle when an entry of CODE_LEN digits completes, else 1
- success  out  1  high after a matching normal entry
- fail_pulse  out  1  1-cycle pulse on a mismatched entry
- led_set_n  out  1  0 while a new code is being entered
- locked  out  1  high during lockout
- digit_cnt  out  $clog2(CODE_LEN+1)  digits in the current buffer

Behaviour:
- Reset values: code_finish_n=1, success=0, fail_pulse=0, led_set_n=1, locked=0, digit_cnt=0; stored code=DEFAULT_CODE; fail counter=0; verify flag=0; entry buffer=0.
- Edge detection: registered previous values of key_sured, key_clear and code_set_req. An edge is prev=0, cur=1. No edge is generated in the first cycle after reset.
- FSM states:
  - IDLE: a key edge -> WAIT, with the delay counter cleared.
  - WAIT: count to SAMPLE_DLY-1, then -> CAPTURE.
  - CAPTURE: write key_value into buffer[digit_cnt] (normal or verify mode) or newcode[digit_cnt] (set mode). Then digit_cnt+1 and clear success. If digit_cnt becomes CODE_LEN -> JUDGE, else -> IDLE.
  - JUDGE (1 cycle): code_finish_n=0 and digit_cnt=0.
    - Set mode: commit newcode to the stored code, led_set_n=1, -> IDLE.
    - Verify flag set: on match, clear the verify flag, led_set_n=0, enter set mode, -> IDLE. On mismatch, clear the verify flag and count as a failure.
    - Normal: on match, success=1 and fail counter=0. On mismatch, fail_pulse=1 and fail counter+1.
    - If the fail counter reaches MAX_FAIL -> LOCK, else -> IDLE.
    - The buffer is zeroed on every exit from JUDGE.
  - LOCK: locked=1; key, clear and set edges are ignored. After LOCK_CYCLES cycles: locked=0, fail counter=0 -> IDLE.
- Comparison is combinational on the full buffer within JUDGE. There is no extra compare cycle; the total latency from the last key edge to code_finish_n=0 is SAMPLE_DLY+2 cycles.
- key_clear edge (not in LOCK): digit_cnt=0, buffer zeroed, FSM -> IDLE, WAIT aborted. In set mode it clears only the partial newcode; the stored code is unchanged and set mode continues.
- code_set_req edge outside LOCK and outside set mode: verify flag=1, digit_cnt=0, buffer zeroed, success=0. An edge already in set mode is ignored.
- Timeout: while digit_cnt>0 and the FSM is in IDLE, an idle counter increments; it resets on any key edge. When it reaches TIMEOUT_CYCLES, the entry is cleared as for key_clear. In set mode, a timeout also exits set mode (led_set_n=1) and keeps the old code. A timeout does not count as a failure.
- Simultaneous edges in one cycle: priority is clear > set_req > key. The lower-priority edges are dropped.
- A key edge during WAIT or CAPTURE is ignored.
- digit_cnt never exceeds CODE_LEN; the write index wraps to 0 only via JUDGE, clear, or timeout.
- Reset mid-operation restores all reset values, including DEFAULT_CODE; a changed code is not retained.

Decomposition:
- Shared package code_lock_pkg: FSM state enum (IDLE, WAIT, CAPTURE, JUDGE, LOCK), the digit_t typedef (logic [DIGIT_W-1:0]), and the function that packs a digit array into a flat vector.
- One sub-module, edge_rise_det (param WIDTH), instantiated once for the 3 input edges.
- Timers stay inline.

Test Plan:
- Key digits 0,1,2,3,4,5 with the default code -> code_finish_n low 1 cycle, SAMPLE_DLY+2 cycles after the 6th edge; success=1; fail_pulse=0; digit_cnt returns to 0.
- Digits 0,1,2,3,4,6 entered three times with MAX_FAIL=3 -> three fail_pulses; locked=1 for exactly LOCK_CYCLES; keys during lockout do not change digit_cnt; afterwards, correct code -> success=1.
- code_set_req edge, then 012345, then 987654 -> led_set_n falls after the 1st JUDGE and rises after the 2nd; 012345 now fails and 987654 gives success=1.
- Digits 1,2,3, then key_clear edge, then 012345 -> digit_cnt 3->0, success=1. Separately, 3 digits followed by TIMEOUT_CYCLES idle -> digit_cnt=0, no fail_pulse.
- key_clear and key_sured rising in the same cycle at digit_cnt=2 -> digit_cnt=0, the key is dropped.
- n_rst asserted mid-entry after a code change -> all outputs return to reset values; 012345 matches again.

Source files
------------

// File: rtl/code_lock_pkg.sv
// ---------------------------------------------------------------------------
// code_lock_pkg
//   Shared types and helpers for the code_lock controller slice.
//   - state_t      : entry-controller FSM states
//   - digit_t      : one keypad digit
//   - pack_digits  : flattens a digit array into a vector, first digit in the
//                    MSBs of the low len*PKG_DIGIT_W bits, higher bits zero
// ---------------------------------------------------------------------------
package code_lock_pkg;

  localparam int PKG_DIGIT_W  = 4;
  localparam int MAX_CODE_LEN = 15;
  localparam int FLAT_W       = PKG_DIGIT_W * MAX_CODE_LEN;

  typedef logic [PKG_DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    CAPTURE = 3'd2,
    JUDGE   = 3'd3,
    LOCK    = 3'd4
  } state_t;

  // Entry i lands at slot (len-1-i) so the packed result lines up with a
  // code literal written first-digit-first (e.g. 24'h012345).
  function automatic logic [FLAT_W-1:0] pack_digits(input digit_t digits [MAX_CODE_LEN],
                                                     input int len);
    logic [FLAT_W-1:0] flat;
    flat = '0;
    for (int i = 0; i < MAX_CODE_LEN; i++) begin
      if (i < len) begin
        flat[(len-1-i)*PKG_DIGIT_W +: PKG_DIGIT_W] = digits[i];
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// code_lock_ctrl_if
//   Keypad-side inputs and display-side outputs of code_lock_ctrl.
//   master : keypad scanner / display side (drives keys, observes status)
//   slave  : the controller
//   Signals: key_sured, key_value, key_clear, code_set_req (to controller);
//            code_finish_n, success, fail_pulse, led_set_n, locked,
//            digit_cnt (from controller).
// ---------------------------------------------------------------------------
interface code_lock_ctrl_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 6
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic               key_sured;
  logic [DIGIT_W-1:0] key_value;
  logic               key_clear;
  logic               code_set_req;
  logic               code_finish_n;
  logic               success;
  logic               fail_pulse;
  logic               led_set_n;
  logic               locked;
  logic [CNT_W-1:0]   digit_cnt;

  modport master (
    output key_sured, key_value, key_clear, code_set_req,
    input  code_finish_n, success, fail_pulse, led_set_n, locked, digit_cnt
  );

  modport slave (
    input  key_sured, key_value, key_clear, code_set_req,
    output code_finish_n, success, fail_pulse, led_set_n, locked, digit_cnt
  );

endinterface

// File: rtl/edge_rise_det.sv
// ---------------------------------------------------------------------------
// edge_rise_det
//   Per-bit rising-edge detector (prev=0, cur=1).
//   Ports: clk, n_rst (async active-low), din[WIDTH], rise[WIDTH].
//   An input already high when reset releases does not produce an edge: the
//   detector is disarmed for the first cycle after reset.
// ---------------------------------------------------------------------------
module edge_rise_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_reg;
  logic             armed_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_reg  <= '0;
      armed_reg <= 1'b0;
    end else begin
      prev_reg  <= din;
      armed_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise[gi] = armed_reg & din[gi] & ~prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// code_lock_ctrl
//   Keypad code-entry controller: collects CODE_LEN digits, compares them to
//   the stored code, handles verified code change, clear, idle timeout and
//   lockout after MAX_FAIL consecutive mismatches.
//   Ports: clk, n_rst (async active-low), io (code_lock_ctrl_if.slave):
//     in : key_sured, key_value, key_clear, code_set_req
//     out: code_finish_n, success, fail_pulse, led_set_n, locked, digit_cnt
//   DIGIT_W must equal code_lock_pkg::PKG_DIGIT_W; CODE_LEN is 2..15.
// ---------------------------------------------------------------------------
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                          DIGIT_W        = PKG_DIGIT_W,
  parameter int                          CODE_LEN       = 6,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE   = 24'h012345,
  parameter int                          SAMPLE_DLY     = 3,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          LOCK_CYCLES    = 50_000_000,
  parameter int                          TIMEOUT_CYCLES = 100_000_000
) (
  input logic            clk,
  input logic            n_rst,
  code_lock_ctrl_if.slave io
);

  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  // Edge detection: bit0 key, bit1 clear, bit2 set request
  logic [2:0] rise;
  logic       key_rise, clr_rise, set_rise;

  edge_rise_det #(.WIDTH(3)) u_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .din   ({io.code_set_req, io.key_clear, io.key_sured}),
    .rise  (rise)
  );

  assign key_rise = rise[0];
  assign clr_rise = rise[1];
  assign set_rise = rise[2];

  // State
  state_t             state_reg, state_next;
  logic [2:0]         dly_cnt_reg;
  logic [CNT_W-1:0]   digit_cnt_reg;
  digit_t             buf_reg     [MAX_CODE_LEN];
  digit_t             newcode_reg [MAX_CODE_LEN];
  logic [FLAT_W-1:0]  code_reg;
  logic [3:0]         fail_cnt_reg;
  logic               verify_reg;
  logic               set_mode_reg;
  logic               success_reg;
  logic               fail_pulse_reg;
  logic [LOCK_W-1:0]  lock_cnt_reg;
  logic [IDLE_W-1:0]  idle_cnt_reg;

  // Decoded actions for this cycle
  logic clear_go, set_go, key_go, timeout_go, capture_go, judge_go, lock_done;
  logic zero_go;
  logic timeout_hit;
  logic entry_match;
  logic fail_now;
  logic [3:0] fail_cnt_judged;
  logic [FLAT_W-1:0] buf_flat, newcode_flat;

  assign buf_flat     = pack_digits(buf_reg, CODE_LEN);
  assign newcode_flat = pack_digits(newcode_reg, CODE_LEN);
  // Unused upper digits are always zero on both sides, so full width compares
  assign entry_match  = (buf_flat == code_reg);

  // In set mode no comparison is made; a verify match does not clear the
  // failure history, only a normal match does.
  assign fail_now = !set_mode_reg && !entry_match;
  always_comb begin
    fail_cnt_judged = fail_cnt_reg;
    if (fail_now) begin
      fail_cnt_judged = fail_cnt_reg + 4'd1;
    end else if (!set_mode_reg && !verify_reg) begin
      fail_cnt_judged = 4'd0;
    end
  end

  assign timeout_hit = (state_reg == IDLE) && (digit_cnt_reg != '0) &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state; clear beats set request beats key, LOCK and JUDGE
  // ignore all edges.
  always_comb begin
    state_next = state_reg;
    clear_go   = 1'b0;
    set_go     = 1'b0;
    key_go     = 1'b0;
    timeout_go = 1'b0;
    capture_go = 1'b0;
    judge_go   = 1'b0;
    lock_done  = 1'b0;
    case (state_reg)
      LOCK: begin
        if (lock_cnt_reg == LOCK_W'(LOCK_CYCLES - 1)) begin
          lock_done  = 1'b1;
          state_next = IDLE;
        end
      end
      JUDGE: begin
        judge_go   = 1'b1;
        state_next = (fail_cnt_judged >= 4'(MAX_FAIL)) ? LOCK : IDLE;
      end
      default: begin
        if (clr_rise) begin
          clear_go   = 1'b1;
          state_next = IDLE;
        end else if (set_rise && !set_mode_reg) begin
          set_go     = 1'b1;
          state_next = IDLE;
        end else begin
          case (state_reg)
            IDLE: begin
              if (key_rise) begin
                key_go     = 1'b1;
                state_next = WAIT;
              end else if (timeout_hit) begin
                timeout_go = 1'b1;
              end
            end
            WAIT: begin
              if (dly_cnt_reg == 3'(SAMPLE_DLY - 1)) begin
                state_next = CAPTURE;
              end
            end
            CAPTURE: begin
              capture_go = 1'b1;
              state_next = (digit_cnt_reg == CNT_W'(CODE_LEN - 1)) ? JUDGE : IDLE;
            end
            default: state_next = IDLE;
          endcase
        end
      end
    endcase
  end

  assign zero_go = clear_go | set_go | timeout_go | judge_go;

  // Datapath and bookkeeping
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dly_cnt_reg    <= '0;
      digit_cnt_reg  <= '0;
      code_reg       <= FLAT_W'(DEFAULT_CODE);
      fail_cnt_reg   <= '0;
      verify_reg     <= 1'b0;
      set_mode_reg   <= 1'b0;
      success_reg    <= 1'b0;
      fail_pulse_reg <= 1'b0;
      lock_cnt_reg   <= '0;
      idle_cnt_reg   <= '0;
      for (int i = 0; i < MAX_CODE_LEN; i++) begin
        buf_reg[i]     <= '0;
        newcode_reg[i] <= '0;
      end
    end else begin
      fail_pulse_reg <= 1'b0;

      if (key_go) begin
        dly_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        dly_cnt_reg <= dly_cnt_reg + 3'd1;
      end

      // Idle timer only runs on a partial entry parked in IDLE
      if ((state_reg == IDLE) && (digit_cnt_reg != '0) && !key_rise && !timeout_hit) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end else begin
        idle_cnt_reg <= '0;
      end

      if (state_reg == LOCK) begin
        lock_cnt_reg <= lock_cnt_reg + 1'b1;
      end else begin
        lock_cnt_reg <= '0;
      end

      if (zero_go) begin
        digit_cnt_reg <= '0;
      end else if (capture_go) begin
        digit_cnt_reg <= digit_cnt_reg + 1'b1;
      end

      for (int i = 0; i < CODE_LEN; i++) begin
        if (zero_go) begin
          buf_reg[i]     <= '0;
          newcode_reg[i] <= '0;
        end else if (capture_go && (digit_cnt_reg == CNT_W'(i))) begin
          if (set_mode_reg) begin
            newcode_reg[i] <= digit_t'(io.key_value);
          end else begin
            buf_reg[i] <= digit_t'(io.key_value);
          end
        end
      end

      if (capture_go) begin
        success_reg <= 1'b0;
      end

      if (set_go) begin
        verify_reg  <= 1'b1;
        success_reg <= 1'b0;
      end

      // Abandoning a new-code entry keeps the old code
      if (timeout_go && set_mode_reg) begin
        set_mode_reg <= 1'b0;
      end

      if (judge_go) begin
        fail_cnt_reg <= fail_cnt_judged;
        if (set_mode_reg) begin
          code_reg     <= newcode_flat;
          set_mode_reg <= 1'b0;
        end else if (verify_reg) begin
          verify_reg <= 1'b0;
          if (entry_match) begin
            set_mode_reg <= 1'b1;
          end else begin
            fail_pulse_reg <= 1'b1;
          end
        end else if (entry_match) begin
          success_reg <= 1'b1;
        end else begin
          fail_pulse_reg <= 1'b1;
        end
      end

      if (lock_done) begin
        fail_cnt_reg <= '0;
      end
    end
  end

  assign io.code_finish_n = (state_reg != JUDGE);
  assign io.success       = success_reg;
  assign io.fail_pulse    = fail_pulse_reg;
  assign io.led_set_n     = ~set_mode_reg;
  assign io.locked        = (state_reg == LOCK);
  assign io.digit_cnt     = digit_cnt_reg;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_code_lock_ctrl
//   Directed scenarios plus randomized entries for code_lock_ctrl, checked
//   against a transaction-level model of the lock (code array, entry queue,
//   mode flags). Short lock/timeout durations keep the run small.
// ---------------------------------------------------------------------------
module tb_code_lock_ctrl;

  localparam int DIGIT_W        = 4;
  localparam int CODE_LEN       = 6;
  localparam int SAMPLE_DLY     = 3;
  localparam int MAX_FAIL       = 3;
  localparam int LOCK_CYCLES    = 40;
  localparam int TIMEOUT_CYCLES = 60;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  code_lock_ctrl_if #(.DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN)) bus ();

  code_lock_ctrl #(
    .DIGIT_W        (DIGIT_W),
    .CODE_LEN       (CODE_LEN),
    .DEFAULT_CODE   (24'h012345),
    .SAMPLE_DLY     (SAMPLE_DLY),
    .MAX_FAIL       (MAX_FAIL),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .io    (bus)
  );

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  // Reference model state
  int m_code [CODE_LEN];
  int m_entry [$];
  bit m_set_mode, m_verify, m_success, m_fail_pulse, m_locked, m_judged;
  int m_fail_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CODE_LEN; i++) m_code[i] = i;
    m_entry.delete();
    m_set_mode = 0; m_verify = 0; m_success = 0; m_fail_pulse = 0;
    m_locked = 0; m_judged = 0; m_fail_cnt = 0;
  endtask

  task automatic model_key(input int d);
    bit match;
    m_judged = 0;
    m_fail_pulse = 0;
    m_success = 0;
    m_entry.push_back(d);
    if (m_entry.size() == CODE_LEN) begin
      m_judged = 1;
      match = 1;
      for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) match = 0;
      if (m_set_mode) begin
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_entry[i];
        m_set_mode = 0;
      end else if (m_verify) begin
        m_verify = 0;
        if (match) m_set_mode = 1;
        else begin m_fail_cnt++; m_fail_pulse = 1; end
      end else if (match) begin
        m_success = 1; m_fail_cnt = 0;
      end else begin
        m_fail_pulse = 1; m_fail_cnt++;
      end
      if (m_fail_cnt >= MAX_FAIL) m_locked = 1;
      m_entry.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".finish_n"},   32'(bus.code_finish_n), 32'd1);
    check_val({tag, ".success"},    32'(bus.success),       32'(m_success));
    check_val({tag, ".fail_pulse"}, 32'(bus.fail_pulse),    32'(m_fail_pulse));
    check_val({tag, ".led_set_n"},  32'(bus.led_set_n),     32'(!m_set_mode));
    check_val({tag, ".locked"},     32'(bus.locked),        32'(m_locked));
    check_val({tag, ".digit_cnt"},  32'(bus.digit_cnt),     32'(m_entry.size()));
  endtask

  // One key press: edge, hold until captured, release, then check results.
  task automatic press(input int d);
    bit full;
    @(negedge clk);
    bus.key_sured = 1'b1;
    bus.key_value = 4'(d);
    model_key(d);
    full = m_judged;
    repeat (SAMPLE_DLY + 1) @(negedge clk);
    check_val("finish_n_early", 32'(bus.code_finish_n), 32'd1);
    @(negedge clk);
    check_val("finish_n_judge", 32'(bus.code_finish_n), full ? 32'd0 : 32'd1);
    check_val("digit_cnt_capt", 32'(bus.digit_cnt), full ? 32'(CODE_LEN) : 32'(m_entry.size()));
    bus.key_sured = 1'b0;
    @(negedge clk);
    check_outputs("after_key");
    if (full && !m_locked) begin
      m_fail_pulse = 0;
      @(negedge clk);
      check_val("fail_pulse_width", 32'(bus.fail_pulse), 32'd0);
    end
  endtask

  // Measures the lockout while poking every input; none may take effect.
  task automatic run_lock();
    int cnt = 0;
    while (bus.locked === 1'b1 && cnt < 4 * LOCK_CYCLES) begin
      cnt++;
      if (cnt == 2)  check_val("lock_fail_pulse_width", 32'(bus.fail_pulse), 32'd0);
      if (cnt == 5)  begin bus.key_sured = 1'b1; bus.key_value = 4'd7; end
      if (cnt == 8)  bus.key_sured = 1'b0;
      if (cnt == 10) bus.key_clear = 1'b1;
      if (cnt == 12) begin
        bus.key_clear = 1'b0;
        check_val("lock_digit_cnt", 32'(bus.digit_cnt), 32'd0);
      end
      if (cnt == 14) bus.code_set_req = 1'b1;
      if (cnt == 16) bus.code_set_req = 1'b0;
      @(negedge clk);
    end
    check_val("lock_len", 32'(cnt), 32'(LOCK_CYCLES));
    m_locked = 0; m_fail_cnt = 0; m_fail_pulse = 0;
    check_outputs("after_lock");
    $display("lockout lasted %0d cycles", cnt);
  endtask

  task automatic enter_code(input int d [CODE_LEN]);
    for (int i = 0; i < CODE_LEN; i++) press(d[i]);
    $display("entry %0d%0d%0d%0d%0d%0d -> success=%0b set_mode=%0b locked=%0b",
             d[0], d[1], d[2], d[3], d[4], d[5], bus.success, !bus.led_set_n, bus.locked);
    if (m_locked) run_lock();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.key_clear = 1'b1;
    m_entry.delete();
    @(negedge clk);
    bus.key_clear = 1'b0;
    check_outputs("clear");
    $display("clear -> digit_cnt=%0d", bus.digit_cnt);
  endtask

  task automatic pulse_set_req();
    @(negedge clk);
    bus.code_set_req = 1'b1;
    if (!m_set_mode) begin
      m_verify = 1; m_entry.delete(); m_success = 0;
    end
    @(negedge clk);
    bus.code_set_req = 1'b0;
    check_outputs("set_req");
    $display("set request -> digit_cnt=%0d", bus.digit_cnt);
  endtask

  // Called with a partial entry parked in IDLE
  task automatic idle_timeout();
    int fp = 0;
    repeat (TIMEOUT_CYCLES - 10) begin
      @(negedge clk);
      if (bus.fail_pulse === 1'b1) fp++;
    end
    check_val("timeout_hold", 32'(bus.digit_cnt), 32'(m_entry.size()));
    repeat (20) begin
      @(negedge clk);
      if (bus.fail_pulse === 1'b1) fp++;
    end
    m_entry.delete();
    m_set_mode = 0;
    check_val("timeout_no_fail_pulse", 32'(fp), 32'd0);
    check_outputs("timeout");
    $display("timeout -> digit_cnt=%0d led_set_n=%0b", bus.digit_cnt, bus.led_set_n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d [CODE_LEN];
    int bad [CODE_LEN];
    int newc [CODE_LEN];
    int n;
    int op;

    model_reset();
    bus.key_sured = 1'b1;     // held high across reset release: must not count
    bus.key_value = 4'd9;
    bus.key_clear = 1'b0;
    bus.code_set_req = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    n_rst = 1'b1;
    repeat (SAMPLE_DLY + 4) @(negedge clk);
    check_outputs("no_edge_after_reset");
    bus.key_sured = 1'b0;

    // Default code accepted
    d = m_code;
    enter_code(d);
    check_val("default_success", 32'(bus.success), 32'd1);

    // Three wrong entries -> lockout, then correct code works
    bad = '{0, 1, 2, 3, 4, 6};
    for (int k = 0; k < MAX_FAIL; k++) enter_code(bad);
    d = m_code;
    enter_code(d);
    check_val("post_lock_success", 32'(bus.success), 32'd1);

    // Code change 012345 -> 987654
    pulse_set_req();
    d = m_code;
    enter_code(d);
    check_val("set_mode_entered", 32'(bus.led_set_n), 32'd0);
    newc = '{9, 8, 7, 6, 5, 4};
    enter_code(newc);
    check_val("set_mode_left", 32'(bus.led_set_n), 32'd1);
    d = '{0, 1, 2, 3, 4, 5};
    enter_code(d);
    check_val("old_code_rejected", 32'(bus.success), 32'd0);
    enter_code(newc);
    check_val("new_code_success", 32'(bus.success), 32'd1);

    // Partial entry then clear
    press(1); press(2); press(3);
    pulse_clear();
    d = m_code;
    enter_code(d);

    // Partial entry then timeout
    press(4); press(4); press(4);
    idle_timeout();

    // Timeout while entering a new code exits set mode, keeps the code
    pulse_set_req();
    d = m_code;
    enter_code(d);
    press(1); press(1);
    idle_timeout();
    d = m_code;
    enter_code(d);

    // Clear and key edge together at digit_cnt=2: key dropped
    press(5); press(6);
    @(negedge clk);
    bus.key_clear = 1'b1;
    bus.key_sured = 1'b1;
    bus.key_value = 4'd9;
    m_entry.delete();
    repeat (SAMPLE_DLY + 3) @(negedge clk);
    check_val("simul_digit_cnt", 32'(bus.digit_cnt), 32'd0);
    bus.key_clear = 1'b0;
    bus.key_sured = 1'b0;

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        d = m_code;
        enter_code(d);
      end else if (op <= 5) begin
        for (int i = 0; i < CODE_LEN; i++) d[i] = $urandom_range(0, 9);
        if (op == 5) d[0] = m_code[0];
        enter_code(d);
      end else if (op == 6) begin
        n = $urandom_range(1, CODE_LEN - 1);
        for (int i = 0; i < n; i++) press($urandom_range(0, 15));
        pulse_clear();
      end else if (op == 7) begin
        pulse_set_req();
      end else if (op == 8) begin
        pulse_set_req();
        d = m_code;
        enter_code(d);
        for (int i = 0; i < CODE_LEN; i++) d[i] = $urandom_range(0, 9);
        enter_code(d);
      end else begin
        n = $urandom_range(1, CODE_LEN - 1);
        for (int i = 0; i < n; i++) press($urandom_range(0, 9));
        idle_timeout();
      end
    end

    // Reset mid-entry after a code change restores the default code
    pulse_set_req();
    d = m_code;
    enter_code(d);
    newc = '{3, 3, 3, 7, 7, 7};
    enter_code(newc);
    press(1); press(2);
    @(negedge clk);
    n_rst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("after_reset");
    d = '{0, 1, 2, 3, 4, 5};
    enter_code(d);
    check_val("default_after_reset", 32'(bus.success), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
